sy_ppl_fpr_freelist: RTL and testbench
======================================

# sy_ppl_fpr_freelist

Floating-point physical-register free list for the rename stage. Hands out free physical FP register indices to newly renamed FP destinations, which later drive the FP register file write and read indices. It reclaims the previous mapping's index at commit and rolls speculative allocations back on a pipeline flush. Storage is a circular buffer with a speculative head, a committed head and a tail.

## Interface
- `PHY_FP_REG`, default 64 (from `sy_pkg`): number of physical FP registers.
- `ARCH_FP_REG`, default 32: number of architectural FP registers.
- `FREE_NUM`, default `PHY_FP_REG-ARCH_FP_REG` = 32: free-list depth. Must be a power of two; elaboration fails otherwise.
- `clk_i` input 1: the single clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `alloc_req_i` input 1: rename requests one FP destination register this cycle.
- `alloc_ready_o` output 1: a free register is available (list not empty).
- `alloc_idx_o` output `PHY_REG_WTH`: index handed out when `alloc_req_i && alloc_ready_o`.
- `commit_alloc_i` input 1: a committing instruction owned an FP allocation; advances the committed head.
- `release_en_i` input 1: commit frees the old physical mapping.
- `release_idx_i` input `PHY_REG_WTH`: index being freed.
- `flush_i` input 1: squash all uncommitted allocations.
- `free_cnt_o` output `$clog2(FREE_NUM)+1`: number of free entries.
- `err_o` output 1: sticky error flag, set on release while the list is full, or on a commit advance past the speculative head.

## Operation
- State:
  - `list[FREE_NUM]` of `PHY_REG_WTH`.
  - Pointers `spec_head`, `cmt_head`, `tail`, each `$clog2(FREE_NUM)+1` bits. The MSB is the wrap bit and the low bits index `list`.
- Counts:
  - `free_cnt_o = tail - spec_head` (modulo 2^ptr width).
  - Empty when `tail == spec_head`.
  - Full when `tail - cmt_head == FREE_NUM`.
- Reset:
  - `list[i] = ARCH_FP_REG + i`.
  - `spec_head = cmt_head = 0`, `tail = FREE_NUM` (wrap bit set, low bits 0).
  - Outputs: `free_cnt_o = FREE_NUM`, `alloc_ready_o = 1`, `alloc_idx_o = ARCH_FP_REG`, `err_o = 0`.
- Allocate: on `alloc_fire = alloc_req_i & alloc_ready_o & ~flush_i`, `spec_head++`. A request while empty is ignored with no state change.
- Release: on `release_en_i`, `list[tail] <= release_idx_i` and `tail++`. Release while full sets `err_o` and drops the write.
- Commit: on `commit_alloc_i`, `cmt_head++`. If this would pass `spec_head`, set `err_o` and hold `cmt_head`.
- Flush: `spec_head <= cmt_head + commit_alloc_i`. Same-cycle commit and release are applied, since they are older than the flush. Same-cycle alloc is dropped.
- A release is never bypassed to a same-cycle allocate. `alloc_ready_o` and `alloc_idx_o` depend on registered state only.
- `err_o` clears only on reset.

## Timing
- `alloc_idx_o` and `alloc_ready_o` are combinational from registers, valid in the same cycle as the request. The pointer update is visible next cycle.
- A released index becomes allocatable one cycle after `release_en_i`.
- After `flush_i`, the first allocation of the next cycle returns the oldest uncommitted index, `list[cmt_head]`.
- Throughput: 1 allocate, 1 release and 1 commit per cycle, concurrently.
- All pointers wrap naturally through the MSB. No special case exists at the array end.
- Asserting reset mid-operation returns all state to the reset values immediately (asynchronous).

## Structure
- `sy_pkg` holds `PHY_FP_REG`, `ARCH_FP_REG` and `PHY_REG_WTH`.
- Add `FP_FREE_NUM` and the typedef `fp_fl_ptr_t` (pointer width) to `sy_pkg`.
- Single module, no sub-module. The circular buffer is simple enough to inline.
- One `always_ff` holds pointers, `list` and `err_o` using the codebase async-reset DFF macros. Count, ready and index are computed in `always_comb`.

## Test plan
- Reset, then 32 back-to-back allocs:
  - `alloc_idx_o` = 32, 33, …, 63.
  - Then `alloc_ready_o = 0` and `free_cnt_o = 0`.
  - A 33rd request changes nothing.
- From empty, release idx 5 → next cycle `alloc_ready_o = 1`, `alloc_idx_o = 5`. In the release cycle itself, `alloc_ready_o` stays 0.
- Alloc 4 (32–35), commit 1, flush → `alloc_idx_o = 33` and `free_cnt_o = 31`. A same-cycle alloc in the flush cycle is ignored.
- Flush coincident with `commit_alloc_i` after 3 allocs and 0 prior commits → `spec_head = 1` and `alloc_idx_o = 33`.
- 100 cycles of random alloc/commit/release with wrap-around → allocated indices are always unique among live mappings, `free_cnt_o` matches the model, and `err_o = 0`.
- Release on a full list → `err_o = 1` on the next cycle, `free_cnt_o` unchanged. Assert `rst_i` mid-sequence → all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/sy_pkg.sv
// Shared rename-stage parameters and the FP free-list pointer type.
package sy_pkg;

  localparam int PHY_FP_REG  = 64;
  localparam int ARCH_FP_REG = 32;
  localparam int PHY_REG_WTH = $clog2(PHY_FP_REG);
  localparam int FP_FREE_NUM = PHY_FP_REG - ARCH_FP_REG;

  // Pointer carries one extra wrap bit above the list index.
  typedef logic [$clog2(FP_FREE_NUM):0] fp_fl_ptr_t;

endpackage

// File: rtl/sy_ppl_fpr_freelist.sv
// FP physical-register free list: circular buffer with speculative head,
// committed head and tail; flush rewinds the speculative head.
module sy_ppl_fpr_freelist #(
  parameter int PHY_FP_REG  = sy_pkg::PHY_FP_REG,
  parameter int ARCH_FP_REG = sy_pkg::ARCH_FP_REG,
  parameter int FREE_NUM    = PHY_FP_REG - ARCH_FP_REG
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           alloc_req_i,
  output logic                           alloc_ready_o,
  output logic [sy_pkg::PHY_REG_WTH-1:0] alloc_idx_o,
  input  logic                           commit_alloc_i,
  input  logic                           release_en_i,
  input  logic [sy_pkg::PHY_REG_WTH-1:0] release_idx_i,
  input  logic                           flush_i,
  output logic [$clog2(FREE_NUM):0]      free_cnt_o,
  output logic                           err_o
);

  localparam int IDX_W = sy_pkg::PHY_REG_WTH;
  localparam int PTR_W = $clog2(FREE_NUM) + 1;
  localparam int LOW_W = PTR_W - 1;

  if (FREE_NUM < 2 || (FREE_NUM & (FREE_NUM - 1)) != 0) begin : g_bad_depth
    $error("sy_ppl_fpr_freelist: FREE_NUM must be a power of two >= 2");
  end

  logic [IDX_W-1:0] list [FREE_NUM];
  logic [PTR_W-1:0] spec_head;
  logic [PTR_W-1:0] cmt_head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] cmt_next;
  logic             full;
  logic             cmt_stall;
  logic             alloc_fire;

  always_comb begin
    free_cnt_o    = tail - spec_head;
    alloc_ready_o = (tail != spec_head);
    alloc_idx_o   = list[spec_head[LOW_W-1:0]];
    full          = ((tail - cmt_head) == PTR_W'(FREE_NUM));
    // Commit can never overtake allocations that actually happened.
    cmt_stall     = (cmt_head == spec_head);
    alloc_fire    = alloc_req_i & alloc_ready_o & ~flush_i;
    cmt_next      = (commit_alloc_i && !cmt_stall) ? cmt_head + PTR_W'(1) : cmt_head;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_head <= '0;
      cmt_head  <= '0;
      tail      <= PTR_W'(FREE_NUM);
      err_o     <= 1'b0;
      for (int i = 0; i < FREE_NUM; i++) begin
        list[i] <= IDX_W'(ARCH_FP_REG + i);
      end
    end else begin
      cmt_head <= cmt_next;
      if (commit_alloc_i && cmt_stall) begin
        err_o <= 1'b1;
      end

      if (release_en_i) begin
        if (full) begin
          err_o <= 1'b1;
        end else begin
          list[tail[LOW_W-1:0]] <= release_idx_i;
          tail                  <= tail + PTR_W'(1);
        end
      end

      // Flush keeps the same-cycle commit, drops the same-cycle allocate.
      if (flush_i) begin
        spec_head <= cmt_next;
      end else if (alloc_fire) begin
        spec_head <= spec_head + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sy_ppl_fpr_freelist.sv
// Bench for the FP free list: queue-based reference model plus an
// allocation scoreboard, directed cases and a random legal traffic run.
module tb_sy_ppl_fpr_freelist;

  localparam int FREE_NUM = 32;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       alloc_req_i = 1'b0;
  logic       alloc_ready_o;
  logic [5:0] alloc_idx_o;
  logic       commit_alloc_i = 1'b0;
  logic       release_en_i = 1'b0;
  logic [5:0] release_idx_i = '0;
  logic       flush_i = 1'b0;
  logic [5:0] free_cnt_o;
  logic       err_o;

  sy_ppl_fpr_freelist dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_req_i    (alloc_req_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_idx_o    (alloc_idx_o),
    .commit_alloc_i (commit_alloc_i),
    .release_en_i   (release_en_i),
    .release_idx_i  (release_idx_i),
    .flush_i        (flush_i),
    .free_cnt_o     (free_cnt_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: free_q holds every not-yet-committed free index in
  // order; the first spec_cnt of them are speculatively handed out.
  int free_q[$];
  int spec_cnt;
  bit err_m;
  int exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    for (int i = 0; i < FREE_NUM; i++) free_q.push_back(32 + i);
    spec_cnt = 0;
    err_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic cycle(input bit req, input bit cmt, input bit rel, input int rel_idx,
                       input bit fl, output bit fired, output int idx);
    bit m_ready, m_full, m_cmt_ok;
    @(negedge clk_i);
    alloc_req_i    = req;
    commit_alloc_i = cmt;
    release_en_i   = rel;
    release_idx_i  = 6'(rel_idx);
    flush_i        = fl;
    #1;
    m_ready = (free_q.size() - spec_cnt) > 0;
    chk("alloc_ready", int'(alloc_ready_o), int'(m_ready));
    chk("free_cnt", int'(free_cnt_o), free_q.size() - spec_cnt);
    chk("err", int'(err_o), int'(err_m));
    if (req && m_ready && !fl) exp_q.push_back(free_q[spec_cnt]);
    fired = req && alloc_ready_o && !fl;
    idx   = int'(alloc_idx_o);
    if (fired) begin
      if (exp_q.size() == 0) chk("alloc_spurious", idx, -1);
      else chk("alloc_idx", idx, exp_q.pop_front());
    end
    while (exp_q.size() > 0) chk("alloc_missing", -1, exp_q.pop_front());

    m_full   = (free_q.size() == FREE_NUM);
    m_cmt_ok = (spec_cnt > 0);
    if (cmt) begin
      if (m_cmt_ok) begin
        void'(free_q.pop_front());
        spec_cnt--;
      end else err_m = 1'b1;
    end
    if (rel) begin
      if (m_full) err_m = 1'b1;
      else free_q.push_back(rel_idx);
    end
    if (fl) spec_cnt = 0;
    else if (req && m_ready) spec_cnt++;
    @(posedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    alloc_req_i = 0; commit_alloc_i = 0; release_en_i = 0; flush_i = 0; release_idx_i = '0;
    #1;
    chk("rst_ready", int'(alloc_ready_o), 1);
    chk("rst_idx", int'(alloc_idx_o), 32);
    chk("rst_free_cnt", int'(free_cnt_o), 32);
    chk("rst_err", int'(err_o), 0);
    model_reset();
    #2 rst_i = 1'b0;
    @(posedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit f;
    int ix;
    int live[$];
    int inflight[$];
    int pending[$];

    model_reset();
    repeat (2) @(posedge clk_i);
    do_reset();

    // Drain the whole list, then an ignored request.
    for (int i = 0; i < 32; i++) begin
      cycle(1, 0, 0, 0, 0, f, ix);
      chk("drain_idx", ix, 32 + i);
    end
    cycle(1, 0, 0, 0, 0, f, ix);
    chk("empty_no_fire", int'(f), 0);
    cycle(0, 0, 0, 0, 0, f, ix);
    chk("empty_cnt", int'(free_cnt_o), 0);

    // Commit everything, then release 5 into an empty list.
    for (int i = 0; i < 32; i++) cycle(0, 1, 0, 0, 0, f, ix);
    cycle(0, 0, 1, 5, 0, f, ix);
    cycle(1, 0, 0, 0, 0, f, ix);
    chk("release_then_alloc", ix, 5);
    chk("release_fired", int'(f), 1);

    // Alloc 4, commit 1, flush with a dropped same-cycle alloc.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, f, ix);
    cycle(0, 1, 0, 0, 0, f, ix);
    cycle(1, 0, 0, 0, 1, f, ix);
    cycle(0, 0, 0, 0, 0, f, ix);
    chk("flush_idx", ix, 33);
    chk("flush_cnt", int'(free_cnt_o), 31);

    // Flush coincident with commit after 3 allocs.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, f, ix);
    cycle(0, 1, 0, 0, 1, f, ix);
    cycle(0, 0, 0, 0, 0, f, ix);
    chk("flush_cmt_idx", ix, 33);
    chk("flush_cmt_cnt", int'(free_cnt_o), 31);

    // Random legal traffic; each commit frees an old mapping one cycle later.
    do_reset();
    for (int i = 0; i < 32; i++) live.push_back(i);
    for (int n = 0; n < 100; n++) begin
      bit req, cmt, rel, fl;
      int rel_idx, dup;
      req = ($urandom_range(0, 9) < 7);
      cmt = (inflight.size() > 0) && ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      rel = (pending.size() > 0);
      rel_idx = rel ? pending.pop_front() : 0;
      cycle(req, cmt, rel, rel_idx, fl, f, ix);
      if (cmt) begin
        int k, nw;
        nw = inflight.pop_front();
        k = $urandom_range(0, live.size() - 1);
        pending.push_back(live[k]);
        live.delete(k);
        live.push_back(nw);
      end
      if (f) begin
        dup = 0;
        foreach (live[j]) if (live[j] == ix) dup = 1;
        foreach (inflight[j]) if (inflight[j] == ix) dup = 1;
        chk("uniq", dup, 0);
        inflight.push_back(ix);
      end
      if (fl) inflight.delete();
    end
    cycle(0, 0, pending.size() > 0, pending.size() > 0 ? pending[0] : 0, 0, f, ix);
    chk("random_err", int'(err_o), 0);

    // Release on a full list, then reset mid-operation.
    do_reset();
    cycle(0, 0, 1, 7, 0, f, ix);
    cycle(0, 0, 0, 0, 0, f, ix);
    chk("full_rel_err", int'(err_o), 1);
    chk("full_rel_cnt", int'(free_cnt_o), 32);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, f, ix);
    do_reset();
    cycle(0, 0, 0, 0, 0, f, ix);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
